lsu_bus_master: RTL
===================

Name: lsu_bus_master

Overview:
CPU-side initiator for the single-outstanding LSU request/response bus; it is the counterpart of the memory/UART responder.
- Accepts one load/store op at a time from the execute stage.
- Drives io_lsu_* with byte-lane-aligned write data and write mask, then waits for io_lsu_respValid.
- Returns loads right-aligned and sign- or zero-extended to the writeback stage.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, bus data width; fixed at 32 (4 byte lanes)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  execute stage presents an op
in_ready  output  1  block can accept an op
in_addr  input  32  byte address
in_wen  input  1  1 = store, 0 = load
in_wdata  input  32  store data, right-aligned
in_size  input  2  00 = byte, 01 = half, 10 = word
in_unsigned  input  1  load zero-extends (lbu/lhu)
out_valid  output  1  result available
out_ready  input  1  writeback accepts the result
out_rdata  output  32  extended load data; 0 for stores
out_err  output  1  misaligned op (only with the optional feature; tied 0 otherwise)
io_lsu_reqValid  output  1  request strobe
io_lsu_addr  output  32  request address, passed through unmodified
io_lsu_wen  output  1  write enable
io_lsu_wdata  output  32  lane-shifted write data
io_lsu_wmask  output  4  byte-lane mask
io_lsu_size  output  2  copy of in_size
io_lsu_rdata  input  32  full aligned word from the responder
io_lsu_respValid  input  1  response strobe

Behaviour:
Registers and encoding
- FSM states: IDLE, REQ, WAIT, DONE.
- Reset returns to IDLE from any state, including mid-transaction. All outputs reset to 0 except in_ready, which resets to 1.
- in_ready = 1 only in IDLE.

IDLE
- On in_valid && in_ready, register addr, wen, size, unsigned and the shifted wdata/wmask, then go to REQ.
- Lane offset: off = in_addr[1:0].
- Write data: io_lsu_wdata = in_wdata << (8*off).
- Write mask base: size 00 -> 4'b0001, 01 -> 4'b0011, 10 -> 4'b1111; io_lsu_wmask = base << off, truncated to 4 bits.
- Size 11 is treated as a word access.
- Loads also drive wmask, for information only.

REQ
- io_lsu_reqValid = 1 for exactly one cycle, then go to WAIT.
- io_lsu_addr, wen, wdata, wmask and size hold stable from REQ until the response is captured.

WAIT
- io_lsu_reqValid = 0; wait indefinitely for io_lsu_respValid.
- On respValid, go to DONE and capture the result:
  - Store: result = 0.
  - Load: r = io_lsu_rdata >> (8*off). Byte -> r[7:0], half -> r[15:0], word -> r. Sign-extend unless unsigned.
- The responder answers one cycle after reqValid, so the minimum op latency is: accept (cycle 0), REQ (1), WAIT sees respValid (2), out_valid (3).

DONE
- out_valid = 1 and out_rdata is held until out_ready; then go to IDLE.
- out_valid && out_ready in the same cycle completes the op. The next op can be accepted in the following cycle, because in_ready only comes back in IDLE.

Boundary conditions
- io_lsu_respValid seen in IDLE, REQ or DONE is ignored.
- A response of 0xdeadbeef (out-of-range address) is passed through like normal data; decoding errors is the consumer's job.
- Misaligned halfword/word accesses without the feature are issued as-is. The shifted mask is truncated, so any lanes beyond byte 3 are dropped.

Optional Feature:
Macro: LSU_MISALIGN_CHECK_EN
- Defined:
  - In IDLE, a half access with addr[0] != 0, or a word access with addr[1:0] != 0, is accepted but no bus request is issued.
  - Go directly to DONE with out_err = 1 and out_rdata = 0.
  - out_err clears when the result is consumed.
- Undefined: out_err is tied to 0 and misaligned accesses issue as described in Behaviour.

Test Plan:
1. Store byte: addr 0x30000101, wdata 0x000000AB, size 00 -> io_lsu_wdata 0x0000AB00, wmask 4'b0010, reqValid high exactly one cycle; responder acks next cycle -> out_valid in cycle 3, out_rdata 0.
2. Load with rdata 0x80112233 returned:
   - lb at 0x30000103 -> out_rdata 0xFFFFFF80.
   - lbu at the same address -> 0x00000080.
   - lh at 0x30000102 -> 0xFFFF8011.
   - lw at 0x30000100 -> 0x80112233.
3. Delayed response and backpressure: respValid withheld for 5 cycles -> FSM stays in WAIT with bus outputs stable. Then hold out_ready = 0 for 3 cycles -> out_valid and out_rdata held, in_ready = 0 throughout.
4. Back-to-back ops with out_ready tied to 1 -> second op accepted the cycle after DONE. Each op issues exactly one reqValid pulse. A spurious respValid injected in IDLE produces no out_valid.
5. Reset mid-operation: assert reset in WAIT -> next cycle in IDLE, in_ready = 1, reqValid = 0, out_valid = 0. A late respValid after reset is ignored.
6. With LSU_MISALIGN_CHECK_EN: lw at 0x30000102 -> no reqValid pulse, out_valid with out_err = 1 and out_rdata = 0. An aligned lw afterwards completes with out_err = 0.

Source files
------------

// File: rtl/lsu_bus_master_if.sv
// lsu_bus_master_if
//   Single-outstanding LSU request/response bus between the CPU-side
//   initiator and the memory/UART responder.
//   master : drives reqValid/addr/wen/wdata/wmask/size, receives rdata/respValid
//   slave  : the responder's view of the same wires
interface lsu_bus_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  reqValid;
  logic [ADDR_W-1:0]     addr;
  logic                  wen;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wmask;
  logic [1:0]            size;
  logic [DATA_W-1:0]     rdata;
  logic                  respValid;

  modport master (
    output reqValid, addr, wen, wdata, wmask, size,
    input  rdata, respValid
  );

  modport slave (
    input  reqValid, addr, wen, wdata, wmask, size,
    output rdata, respValid
  );
endinterface

// File: rtl/lsu_bus_master.sv
// lsu_bus_master
//   CPU-side initiator for the LSU bus. Takes one load/store at a time from
//   execute, issues a single request with lane-aligned data and byte mask,
//   waits for the response and returns loads right-aligned and extended.
//
// Ports
//   clock, reset             : system clock, synchronous active-high reset
//   in_valid/in_ready        : op handshake from execute (in_ready only in IDLE)
//   in_addr/in_wen/in_wdata  : byte address, store flag, right-aligned store data
//   in_size/in_unsigned      : 00 byte, 01 half, 1x word; zero-extend loads
//   out_valid/out_ready      : result handshake to writeback
//   out_rdata/out_err        : extended load data (0 for stores), misalign flag
//   io_lsu                   : LSU bus, master modport
//
// Build option
//   LSU_MISALIGN_CHECK_EN : misaligned half/word ops complete immediately with
//                           out_err = 1 and no bus request. Undefined: out_err
//                           is tied to 0 and misaligned ops are issued as-is.
//
// state  | meaning
// IDLE   | ready for a new op
// REQ    | reqValid strobe, single cycle
// WAIT   | request issued, waiting for respValid
// DONE   | result presented until writeback takes it
module lsu_bus_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_wen,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rdata,
  output logic              out_err,
  lsu_bus_master_if.master  io_lsu
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wen;
  logic [DATA_W-1:0]   r_wdata;
  logic [3:0]          r_wmask;
  logic [1:0]          r_size;
  logic                r_unsigned;
  logic [DATA_W-1:0]   r_rdata;

  logic                w_accept;
  logic                w_misalign;
  logic [3:0]          w_mask_base;
  logic [DATA_W-1:0]   w_shift;
  logic [DATA_W-1:0]   w_result;

  assign w_accept = (r_state == S_IDLE) && in_valid;

`ifdef LSU_MISALIGN_CHECK_EN
  logic r_err;

  // size 11 is treated as a word, so in_size[1] covers both word encodings
  assign w_misalign = ((in_size == 2'b01) && in_addr[0]) ||
                      (in_size[1] && (in_addr[1:0] != 2'b00));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= w_misalign;
    end else if ((r_state == S_DONE) && out_ready) begin
      r_err <= 1'b0;
    end
  end

  assign out_err = r_err;
`else
  assign w_misalign = 1'b0;
  assign out_err    = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    in_ready        = 1'b0;
    out_valid       = 1'b0;
    io_lsu.reqValid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = w_misalign ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        io_lsu.reqValid = 1'b1;
        w_state_nxt     = S_WAIT;
      end
      S_WAIT: begin
        if (io_lsu.respValid) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_mask_base = 4'b1111;
    case (in_size)
      2'b00:   w_mask_base = 4'b0001;
      2'b01:   w_mask_base = 4'b0011;
      default: w_mask_base = 4'b1111;
    endcase
  end

  // Response lanes are moved down to bit 0 before extension; lanes shifted
  // past byte 3 come in as zero.
  always_comb begin
    w_shift  = io_lsu.rdata >> {r_addr[1:0], 3'b000};
    w_result = '0;
    if (!r_wen) begin
      case (r_size)
        2'b00:   w_result = r_unsigned ? {{(DATA_W-8){1'b0}}, w_shift[7:0]}
                                       : {{(DATA_W-8){w_shift[7]}}, w_shift[7:0]};
        2'b01:   w_result = r_unsigned ? {{(DATA_W-16){1'b0}}, w_shift[15:0]}
                                       : {{(DATA_W-16){w_shift[15]}}, w_shift[15:0]};
        default: w_result = w_shift;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr     <= '0;
      r_wen      <= 1'b0;
      r_wdata    <= '0;
      r_wmask    <= 4'b0000;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_rdata    <= '0;
    end else begin
      if (w_accept) begin
        r_addr     <= in_addr;
        r_wen      <= in_wen;
        r_size     <= in_size;
        r_unsigned <= in_unsigned;
        r_wdata    <= in_wdata << {in_addr[1:0], 3'b000};
        r_wmask    <= w_mask_base << in_addr[1:0];
        r_rdata    <= '0;
      end
      if ((r_state == S_WAIT) && io_lsu.respValid) begin
        r_rdata <= w_result;
      end
    end
  end

  assign io_lsu.addr  = r_addr;
  assign io_lsu.wen   = r_wen;
  assign io_lsu.wdata = r_wdata;
  assign io_lsu.wmask = r_wmask;
  assign io_lsu.size  = r_size;
  assign out_rdata    = r_rdata;

endmodule
